// File: rtl/axi_pkg.sv
// Shared AXI constants and the read-arbiter state encoding.
package axi_pkg;

  // AXI burst types
  localparam logic [1:0] AXI_BURST_FIXED = 2'd0;
  localparam logic [1:0] AXI_BURST_INCR  = 2'd1;
  localparam logic [1:0] AXI_BURST_WRAP  = 2'd2;

  // AXI response codes
  localparam logic [1:0] AXI_RESP_OKAY   = 2'd0;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'd2;

  // Read-arbiter FSM encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;

  // One-hot select for a two-requester index
  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin winner select. The pointer holds the requester that
// completed the most recent burst; the other one wins a tie.
module rr_arbiter2 (
  input  logic       aclk,
  input  logic       areset,
  input  logic [1:0] req_valid,
  input  logic       update,
  input  logic       update_idx,
  output logic       any_valid,
  output logic       winner
);

  logic last_grant;

  // Pick the winner from the current requests and the pointer
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it unassigned (no latch).
    any_valid = |req_valid;
    winner    = 1'b0;
    case (req_valid)
      2'b11:   winner = ~last_grant;
      2'b10:   winner = 1'b1;
      default: winner = 1'b0;
    endcase
  end

  // Pointer register: reset so requester 0 wins the first tie
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= update_idx;
    end
  end

endmodule

// File: rtl/axi_read_arbiter.sv
// Shares the AXI4 read channel of a single slave between two requesters.
// A descriptor is accepted in IDLE, issued on AR, and the R beats are steered
// back to the granted requester until rlast.
module axi_read_arbiter
  import axi_pkg::*;
#(
  parameter int         ADDRESS_WIDTH = 8,
  parameter int         DATA_WIDTH    = 32,
  parameter logic [2:0] BURST_SIZE    = 3'd2,
  parameter logic [1:0] BURST_TYPE    = AXI_BURST_INCR
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [1:0]                 req_valid,
  output logic [1:0]                 req_ready,
  input  logic [2*ADDRESS_WIDTH-1:0] req_addr,
  input  logic [15:0]                req_len,
  output logic [1:0]                 rd_valid,
  input  logic [1:0]                 rd_ready,
  output logic [DATA_WIDTH-1:0]      rd_data,
  output logic [1:0]                 rd_resp,
  output logic                       rd_last,
  output logic                       grant,
  output logic                       busy,
  output logic                       protocol_err,
  output logic [ADDRESS_WIDTH-1:0]   araddr,
  output logic [7:0]                 arlen,
  output logic [2:0]                 arsize,
  output logic [1:0]                 arburst,
  output logic                       arvalid,
  input  logic                       arready,
  input  logic [DATA_WIDTH-1:0]      rdata,
  input  logic [1:0]                 rresp,
  input  logic                       rlast,
  input  logic                       rvalid,
  output logic                       rready
);

  logic [1:0] state;
  logic [7:0] beat_cnt;
  logic       any_valid;
  logic       winner;
  logic       req_fire;
  logic       beat_fire;
  logic       burst_done;

  rr_arbiter2 u_rr (
    .aclk       (aclk),
    .areset     (areset),
    .req_valid  (req_valid),
    .update     (burst_done),
    .update_idx (grant),
    .any_valid  (any_valid),
    .winner     (winner)
  );

  // Handshake outputs and R-channel steering, decoded from the state
  always_comb begin
    req_ready = 2'b00;
    rd_valid  = 2'b00;
    arvalid   = 1'b0;
    rready    = 1'b0;
    rd_last   = 1'b0;
    case (state)
      ST_IDLE: if (any_valid) req_ready = onehot2(winner);
      ST_ADDR: arvalid = 1'b1;
      ST_DATA: begin
        rready   = rd_ready[grant];
        rd_valid = rvalid ? onehot2(grant) : 2'b00;
        rd_last  = rlast;
      end
      default: ;
    endcase
  end

  assign rd_data    = rdata;
  assign rd_resp    = rresp;
  assign busy       = (state != ST_IDLE);
  assign arsize     = BURST_SIZE;
  assign arburst    = BURST_TYPE;
  assign req_fire   = |(req_valid & req_ready);
  assign beat_fire  = rvalid & rready;
  assign burst_done = beat_fire & rlast;

  // Sequencing: accept a descriptor, issue AR, count beats until rlast
  always_ff @(posedge aclk or posedge areset) begin
    // NOTE: non-blocking assignments so every register here sees pre-edge values of the others.
    if (areset) begin
      state        <= ST_IDLE;
      araddr       <= '0;
      arlen        <= '0;
      grant        <= 1'b1;
      beat_cnt     <= '0;
      protocol_err <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_fire) begin
            araddr   <= winner ? req_addr[2*ADDRESS_WIDTH-1:ADDRESS_WIDTH]
                               : req_addr[ADDRESS_WIDTH-1:0];
            arlen    <= winner ? req_len[15:8] : req_len[7:0];
            beat_cnt <= winner ? req_len[15:8] : req_len[7:0];
            grant    <= winner;
            state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (arready) state <= ST_DATA;
        end
        ST_DATA: begin
          if (beat_fire) begin
            if (beat_cnt != 8'd0) beat_cnt <= beat_cnt - 8'd1;
            // The slave decides where the burst ends; a disagreement with
            // arlen is only recorded.
            if (rlast != (beat_cnt == 8'd0)) protocol_err <= 1'b1;
            if (rlast) state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// Self-checking bench for axi_read_arbiter: a behavioural AXI slave, two
// descriptor queues as requesters, and a transaction-level reference model.
module tb_axi_read_arbiter;
  import axi_pkg::*;

  typedef struct packed {
    logic [7:0] addr;
    logic [7:0] len;
  } desc_t;

  logic        aclk;
  logic        areset;
  logic [1:0]  req_valid;
  logic [1:0]  req_ready;
  logic [15:0] req_addr;
  logic [15:0] req_len;
  logic [1:0]  rd_valid;
  logic [1:0]  rd_ready;
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;
  logic        rd_last;
  logic        grant;
  logic        busy;
  logic        protocol_err;
  logic [7:0]  araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  axi_read_arbiter dut (
    .aclk(aclk), .areset(areset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_resp(rd_resp),
    .rd_last(rd_last), .grant(grant), .busy(busy), .protocol_err(protocol_err),
    .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  int n_assert = 0;
  int n_fail   = 0;

  // Requesters: pending descriptors, accepted-beat counters, grant history
  desc_t req_q [2][$];
  int    beats_rx [2];
  int    grant_log [$];

  // Reference model of the transaction in flight
  int         exp_req      = -1;
  logic [7:0] exp_addr     = '0;
  int         exp_len      = 0;
  int         exp_beat     = 0;
  int         exp_last_idx = 0;
  bit         ar_pending   = 1'b0;
  bit         exp_grant    = 1'b1;
  bit         exp_perr     = 1'b0;
  bit         last_served  = 1'b1;

  // Stimulus knobs
  int         mismatch_at  = -1;
  bit         ar_rand      = 1'b0;
  bit         rv_rand      = 1'b0;
  bit         bp_rand      = 1'b0;
  bit         ar_hold      = 1'b0;
  logic [1:0] rd_ready_cfg = 2'b11;
  logic [1:0] resp_cfg     = AXI_RESP_OKAY;

  // Slave state
  bit         sl_busy = 1'b0;
  logic [7:0] sl_addr = '0;
  int         sl_beat = 0;
  int         sl_last = 0;

  // Values sampled on the falling edge
  logic [1:0] s_hs_req;
  bit         s_hs_ar;
  bit         s_hs_r;
  logic [7:0] s_araddr;
  logic [7:0] s_arlen;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] beat_word(input logic [7:0] a, input int k);
    logic [15:0] mix;
    mix = 16'(a) * 16'd151 + 16'(k) * 16'd37;
    return {a, 8'(k), mix ^ 16'h5a5a};
  endfunction

  function automatic bit model_idle();
    return (exp_req < 0) && !ar_pending && (req_q[0].size() == 0) && (req_q[1].size() == 0);
  endfunction

  // Bus process: sample and check on the falling edge, drive after the rising edge
  initial begin : bus
    req_valid = 2'b00; req_addr = '0; req_len = '0; rd_ready = 2'b11;
    arready = 1'b0; rvalid = 1'b0; rdata = '0; rresp = '0; rlast = 1'b0;
    forever begin
      bit         in_data;
      bit         exp_w;
      logic [1:0] exp_rr;
      desc_t      d;
      int         idx;
      @(negedge aclk);
      s_hs_req = req_valid & req_ready;
      s_hs_ar  = arvalid & arready;
      s_hs_r   = rvalid & rready;
      s_araddr = araddr;
      s_arlen  = arlen;

      // Idle: the waiting requester not served last wins, else whoever waits
      exp_rr = 2'b00;
      if (exp_req < 0) begin
        exp_w = req_valid[!last_served] ? !last_served : last_served;
        if (req_valid != 2'b00) exp_rr = exp_w ? 2'b10 : 2'b01;
      end
      check("req_ready", req_ready, exp_rr);
      check("busy", busy, exp_req >= 0);
      check("grant", grant, exp_grant);
      check("arvalid", arvalid, ar_pending);
      if (ar_pending) begin
        check("araddr", araddr, exp_addr);
        check("arlen", arlen, 8'(exp_len));
      end
      check("arsize", arsize, 3'd2);
      check("arburst", arburst, 2'd1);
      in_data = (exp_req >= 0) && !ar_pending;
      if (in_data) begin
        check("rready", rready, rd_ready[exp_req]);
        check("rd_valid", rd_valid, rvalid ? (2'b01 << exp_req) : 2'b00);
        if (rvalid) begin
          check("rd_data", rd_data, beat_word(exp_addr, exp_beat));
          check("rd_last", rd_last, exp_beat == exp_last_idx);
          check("rd_resp", rd_resp, rresp);
        end
      end else begin
        check("rready", rready, 1'b0);
        check("rd_valid", rd_valid, 2'b00);
      end
      check("protocol_err", protocol_err, exp_perr);

      @(posedge aclk); #1;
      if (areset) begin
        exp_req = -1; ar_pending = 1'b0; exp_grant = 1'b1; exp_perr = 1'b0; last_served = 1'b1;
        req_q[0].delete(); req_q[1].delete();
        sl_busy = 1'b0; arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; req_valid = 2'b00;
      end else begin
        // Beat retired at this edge
        if (s_hs_r && in_data) begin
          beats_rx[exp_req]++;
          if ((exp_beat == exp_last_idx) != (exp_beat >= exp_len)) exp_perr = 1'b1;
          if (exp_beat == exp_last_idx) begin
            last_served = exp_req[0];
            exp_req     = -1;
          end else begin
            exp_beat++;
          end
        end
        if (s_hs_r && sl_busy) begin
          if (sl_beat == sl_last) sl_busy = 1'b0;
          else sl_beat++;
        end
        // Address accepted by the slave
        if (s_hs_ar) begin
          ar_pending = 1'b0;
          sl_busy = 1'b1; sl_addr = s_araddr; sl_beat = 0;
          sl_last = (mismatch_at >= 0) ? mismatch_at : int'(s_arlen);
          mismatch_at = -1;
        end
        // Descriptor accepted by the arbiter
        if (s_hs_req != 2'b00) begin
          idx = s_hs_req[1] ? 1 : 0;
          if (req_q[idx].size() > 0) begin
            d = req_q[idx].pop_front();
            exp_req = idx; exp_addr = d.addr; exp_len = int'(d.len); exp_beat = 0;
            exp_last_idx = (mismatch_at >= 0) ? mismatch_at : int'(d.len);
            ar_pending = 1'b1; exp_grant = idx[0];
            grant_log.push_back(idx);
          end
        end
        // Slave outputs
        arready = !sl_busy && !ar_hold && (!ar_rand || ($urandom_range(0, 1) == 1));
        if (!sl_busy) rvalid = 1'b0;
        else if (!rvalid || s_hs_r) rvalid = !rv_rand || ($urandom_range(0, 1) == 1);
        rdata = beat_word(sl_addr, sl_beat);
        rlast = sl_busy && (sl_beat == sl_last);
        rresp = resp_cfg;
        // Requester outputs
        for (int i = 0; i < 2; i++) begin
          req_valid[i] = (req_q[i].size() > 0);
          if (req_q[i].size() > 0) begin
            req_addr[i*8 +: 8] = req_q[i][0].addr;
            req_len[i*8 +: 8]  = req_q[i][0].len;
          end
        end
        rd_ready = rd_ready_cfg & (bp_rand ? 2'($urandom_range(0, 3)) : 2'b11);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge aclk);
    #2;
  endtask

  task automatic wait_idle(input string tag, input int budget);
    int k = 0;
    do begin step(1); k++; end while (!model_idle() && k < budget);
    check(tag, model_idle(), 1'b1);
  endtask

  task automatic wait_beats(input string tag, input int i, input int n, input int budget);
    int k = 0;
    while (beats_rx[i] < n && k < budget) begin step(1); k++; end
    check(tag, beats_rx[i] >= n, 1'b1);
  endtask

  task automatic do_reset();
    areset = 1'b1;
    step(2);
    areset = 1'b0;
    step(1);
  endtask

  initial begin : main
    int    k;
    int    b;
    int    exp_total;
    int    fair_exp [6];
    desc_t d;
    areset = 1'b1;
    step(3);
    check("rst_arvalid", arvalid, 1'b0);
    check("rst_rready", rready, 1'b0);
    check("rst_req_ready", req_ready, 2'b00);
    check("rst_rd_valid", rd_valid, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_araddr", araddr, 8'd0);
    check("rst_arlen", arlen, 8'd0);
    check("rst_rd_last", rd_last, 1'b0);
    check("rst_perr", protocol_err, 1'b0);
    check("rst_grant", grant, 1'b1);
    areset = 1'b0;
    step(1);

    // Single request from requester 0
    beats_rx = '{0, 0};
    req_q[0].push_back('{addr: 8'h07, len: 8'd5});
    k = 0;
    do begin step(1); k++; end while (!req_ready[0] && k < 20);
    check("t1_req_ready", req_ready, 2'b01);
    check("t1_arvalid_pre", arvalid, 1'b0);
    step(1);
    check("t1_arvalid", arvalid, 1'b1);
    check("t1_araddr", araddr, 8'h07);
    check("t1_arlen", arlen, 8'd5);
    check("t1_arsize", arsize, 3'd2);
    check("t1_arburst", arburst, 2'd1);
    wait_idle("t1_idle", 200);
    check("t1_beats0", beats_rx[0], 6);
    check("t1_beats1", beats_rx[1], 0);
    check("t1_busy", busy, 1'b0);
    check("t1_perr", protocol_err, 1'b0);

    // Simultaneous requests out of reset
    do_reset();
    grant_log.delete(); beats_rx = '{0, 0};
    req_q[0].push_back('{addr: 8'h10, len: 8'd1});
    req_q[1].push_back('{addr: 8'h40, len: 8'd2});
    wait_idle("t2_idle", 200);
    check("t2_ngrants", grant_log.size(), 2);
    check("t2_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    check("t2_second", (grant_log.size() > 1) ? grant_log[1] : -1, 1);
    check("t2_beats0", beats_rx[0], 2);
    check("t2_beats1", beats_rx[1], 3);

    // Fairness with random slave timing and requester backpressure
    ar_rand = 1'b1; rv_rand = 1'b1; bp_rand = 1'b1;
    grant_log.delete();
    for (int i = 0; i < 4; i++) begin
      d.addr = 8'($urandom); d.len = 8'($urandom_range(0, 3));
      req_q[0].push_back(d);
    end
    for (int i = 0; i < 2; i++) begin
      d.addr = 8'($urandom); d.len = 8'($urandom_range(0, 3));
      req_q[1].push_back(d);
    end
    wait_idle("t3_idle", 1500);
    fair_exp = '{0, 1, 0, 1, 0, 0};
    check("t3_ngrants", grant_log.size(), 6);
    for (int i = 0; i < 6; i++)
      check($sformatf("t3_grant%0d", i), (grant_log.size() > i) ? grant_log[i] : -1, fair_exp[i]);

    // Random traffic, requester 1 arriving in pulses
    beats_rx = '{0, 0}; exp_total = 0;
    for (int it = 0; it < 30; it++) begin
      step($urandom_range(1, 6));
      d.addr = 8'($urandom); d.len = 8'($urandom_range(0, 7));
      req_q[$urandom_range(0, 1)].push_back(d);
      exp_total += int'(d.len) + 1;
    end
    wait_idle("rand_idle", 4000);
    check("rand_beats", beats_rx[0] + beats_rx[1], exp_total);
    ar_rand = 1'b0; rv_rand = 1'b0; bp_rand = 1'b0;

    // Backpressure mid-burst, then AR stall
    beats_rx = '{0, 0};
    req_q[0].push_back('{addr: 8'h20, len: 8'd7});
    wait_beats("t4_start", 0, 3, 100);
    rd_ready_cfg = 2'b10;
    step(1);
    b = beats_rx[0];
    for (int i = 0; i < 3; i++) begin
      check("t4_rready_low", rready, 1'b0);
      check("t4_no_beat", beats_rx[0], b);
      if (i < 2) step(1);
    end
    rd_ready_cfg = 2'b11;
    wait_idle("t4_idle", 200);
    check("t4_beats", beats_rx[0], 8);
    ar_hold = 1'b1;
    req_q[1].push_back('{addr: 8'h33, len: 8'd0});
    step(3);
    for (int i = 0; i < 3; i++) begin
      check("t4_ar_hold_valid", arvalid, 1'b1);
      check("t4_ar_hold_addr", araddr, 8'h33);
      check("t4_ar_hold_len", arlen, 8'd0);
      step(1);
    end
    ar_hold = 1'b0;
    wait_idle("t4_ar_idle", 100);
    check("t4_ar_beats", beats_rx[1], 1);

    // Early rlast with an error response
    beats_rx = '{0, 0};
    mismatch_at = 2;
    resp_cfg = AXI_RESP_SLVERR;
    req_q[0].push_back('{addr: 8'h50, len: 8'd5});
    wait_idle("t5_idle", 200);
    check("t5_perr", protocol_err, 1'b1);
    check("t5_beats", beats_rx[0], 3);
    check("t5_busy", busy, 1'b0);
    resp_cfg = AXI_RESP_OKAY;
    req_q[1].push_back('{addr: 8'h60, len: 8'd1});
    wait_idle("t5_next_idle", 200);
    check("t5_next_beats", beats_rx[1], 2);
    check("t5_perr_sticky", protocol_err, 1'b1);

    // Reset in the middle of a data phase
    beats_rx = '{0, 0};
    req_q[0].push_back('{addr: 8'h70, len: 8'd7});
    wait_beats("t6_start", 0, 2, 100);
    areset = 1'b1;
    #1;
    check("t6_arvalid", arvalid, 1'b0);
    check("t6_rready", rready, 1'b0);
    check("t6_rd_valid", rd_valid, 2'b00);
    check("t6_busy", busy, 1'b0);
    check("t6_perr", protocol_err, 1'b0);
    check("t6_grant", grant, 1'b1);
    #1;
    step(2);
    areset = 1'b0;
    step(1);
    grant_log.delete(); beats_rx = '{0, 0};
    req_q[1].push_back('{addr: 8'h80, len: 8'd1});
    req_q[0].push_back('{addr: 8'h90, len: 8'd2});
    wait_idle("t6_idle", 200);
    check("t6_first", (grant_log.size() > 0) ? grant_log[0] : -1, 0);
    check("t6_second", (grant_log.size() > 1) ? grant_log[1] : -1, 1);
    check("t6_beats0", beats_rx[0], 3);
    check("t6_beats1", beats_rx[1], 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_read_arbiter.md
Name: axi_read_arbiter

Overview:
- Shares the single AXI4 read channel of axi_slave_ram between two internal requesters.
- Each requester submits a burst descriptor (start address, length). The arbiter grants requests round-robin, drives AR, and steers R beats back to the granted requester until rlast.
- Sits directly in front of axi_slave_ram and owns its AR/R master side.

Parameters:
- ADDRESS_WIDTH, 8, width of araddr and of each requester address.
- DATA_WIDTH, 32, width of rdata.
- BURST_SIZE, 2, constant driven on arsize (log2 bytes per beat).
- BURST_TYPE, 1, constant driven on arburst (INCR).

Ports:
- aclk  in  1  clock, all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- req_valid  in  2  bit i: requester i has a descriptor.
- req_ready  out  2  bit i: descriptor i accepted this cycle.
- req_addr  in  2*ADDRESS_WIDTH  slice i = start address of requester i.
- req_len  in  2*8  slice i = arlen of requester i (beats-1).
- rd_valid  out  2  bit i: beat for requester i valid.
- rd_ready  in  2  bit i: requester i accepts beat.
- rd_data  out  DATA_WIDTH  beat data, shared bus, qualify with rd_valid.
- rd_resp  out  2  rresp of the current beat.
- rd_last  out  1  last beat of the current burst.
- grant  out  1  index of the current/last granted requester.
- busy  out  1  high outside IDLE.
- protocol_err  out  1  sticky: rlast mismatched against arlen.
- araddr  out  ADDRESS_WIDTH  AXI AR address.
- arlen  out  8  AXI AR length.
- arsize  out  3  AXI AR size = BURST_SIZE.
- arburst  out  2  AXI AR burst = BURST_TYPE.
- arvalid  out  1  AXI AR valid.
- arready  in  1  AXI AR ready.
- rdata  in  DATA_WIDTH  AXI R data.
- rresp  in  2  AXI R response.
- rlast  in  1  AXI R last.
- rvalid  in  1  AXI R valid.
- rready  out  1  AXI R ready.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-burst):
  - state=IDLE; arvalid=0, rready=0, req_ready=0, rd_valid=0, busy=0.
  - araddr=0, arlen=0, rd_last=0, protocol_err=0.
  - grant=1, last_grant=1, so requester 0 wins first.
  - An in-flight burst is abandoned; no beats are forwarded after reset.
- IDLE:
  - Winner = the valid requester that is not last_grant; if only one is valid, that one.
  - req_ready[winner]=1 combinationally; never more than one req_ready bit high.
  - On req_valid&req_ready: latch that requester's addr/len into araddr/arlen, set grant=winner, load beat counter = len, go to ADDR next cycle.
- ADDR:
  - arvalid=1; araddr/arlen held stable until handshake.
  - On arvalid&arready: go to DATA. arvalid is first seen high the cycle after acceptance (latency 1).
- DATA:
  - rready = rd_ready[grant]; rd_valid[grant] = rvalid; other rd_valid bit = 0.
  - rd_data/rd_resp/rd_last pass through combinationally.
  - Per beat (rvalid&rready): the counter decrements.
  - Beat with rlast=1: last_grant=grant, go to IDLE.
  - If rlast arrives with counter!=0, or counter==0 without rlast: set protocol_err. The state still follows rlast.
- rready=0 and arvalid=0 in every state except DATA and ADDR respectively.
- No new request is accepted in ADDR or DATA; req_valid held by requesters is simply not acknowledged.
- One outstanding burst at a time; a new grant needs at least one IDLE cycle.
- Back-to-back from the same requester is allowed when the other is idle.
- rresp is forwarded unmodified; error responses do not alter sequencing.
- arsize/arburst are constant outputs.

Decomposition:
- Shared package axi_pkg:
  - AXI burst type constants (FIXED=0, INCR=1, WRAP=2) and response codes (OKAY=0, SLVERR=2).
  - Arbiter state encoding (IDLE, ADDR, DATA).
- One natural sub-module: rr_arbiter2, the two-way round-robin winner select from req_valid and last_grant (combinational plus pointer register). Everything else stays in the top.

Test Plan:
- Single request: req 0, addr=7, len=5; slave ready -> arvalid one cycle after req_ready[0], araddr=7, arlen=5, arsize=2, arburst=1. Six beats reach rd_valid[0] only; busy drops after rlast; protocol_err=0.
- Simultaneous requests: both valid (addr 0x10 len 1, addr 0x40 len 2) out of reset -> requester 0 served first (2 beats), then requester 1 (3 beats); grant toggles 0 then 1.
- Fairness: requester 0 holds req_valid continuously, requester 1 pulses -> grants alternate 0,1,0 while both are valid; requester 0 is never granted twice in a row while 1 waits.
- Backpressure: rd_ready[0] low for 3 cycles mid-burst -> rready low over those cycles, no beat lost or duplicated, data order preserved; arvalid held stable while arready=0.
- Mismatch: slave asserts rlast on beat 3 of a len=5 burst -> protocol_err=1 (sticky), state returns to IDLE, next request served normally.
- Reset mid-DATA: areset asserted after beat 2 -> arvalid/rready/rd_valid drop 0 in the same cycle. After release, requester 0 is granted first again.
